fp_accum_seq: RTL and testbench
===============================

FP_ACCUM_SEQ -- requirements
Module: fp_accum_seq

Interface
REQ-001 SHALL have parameter COUNT_W, default 8, width of the term counter.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  operand present on in_data.
REQ-005 SHALL have port in_data  input  32  IEEE-754 single-precision term.
REQ-006 SHALL have port in_last  input  1  marks the final term of a group.
REQ-007 SHALL have port in_ready  output  1  block accepts a term this cycle.
REQ-008 SHALL have port add_load  output  1  load strobe to the downstream FP adder.
REQ-009 SHALL have port add_num1, add_num2  output  32 each  adder operands (accumulator, term).
REQ-010 SHALL have port add_result  input  32  adder sum.
REQ-011 SHALL have port add_ready  input  1  adder sum valid.
REQ-012 SHALL have port add_ack  output  1  sum consumed; releases the adder.
REQ-013 SHALL have port out_valid  output  1  group sum available.
REQ-014 SHALL have port out_data  output  32  group sum.
REQ-015 SHALL have port out_count  output  COUNT_W  number of terms in the group.
REQ-016 SHALL have port out_ready  input  1  consumer takes the group sum.

Function
REQ-017 SHALL implement states IDLE, ISSUE, WAIT, DONE; in_ready=1 only in IDLE.
REQ-018 Transfer SHALL occur on in_valid && in_ready; the term is latched into an operand register, and in_last is latched with it.
REQ-019 First term of a group (count==0) SHALL be written directly to the accumulator with no adder transaction.
REQ-020 Zero bypass: if term[30:0]==0, the accumulator SHALL be unchanged; if accumulator[30:0]==0, it SHALL take the term. In both cases there is no adder transaction.
REQ-021 Otherwise IDLE->ISSUE; in ISSUE, add_load=1 for exactly one cycle with add_num1=accumulator and add_num2=term, then ->WAIT.
REQ-022 add_num1/add_num2 SHALL hold stable from ISSUE until add_ack.
REQ-023 WAIT SHALL wait indefinitely for add_ready; on add_ready=1 the accumulator captures add_result and add_ack=1 for that single cycle.
REQ-024 After capture (or after a direct/bypass write in IDLE), the block SHALL go to DONE if the latched last=1, else to IDLE.
REQ-025 out_count SHALL increment once per accepted term, including bypassed terms, and saturate at 2^COUNT_W-1.
REQ-026 In DONE: out_valid=1, out_data=accumulator, out_count=count; these are stable until out_ready.
REQ-027 On out_valid && out_ready: accumulator and count SHALL clear to 0, ->IDLE; the next term may be accepted the following cycle.
REQ-028 add_load and add_ack SHALL never be asserted in the same cycle.
REQ-029 add_ready outside WAIT SHALL be ignored and SHALL NOT produce add_ack.
REQ-030 Single-term group latency: accepting edge -> out_valid next cycle.

Reset
REQ-031 reset=0 SHALL immediately force IDLE and clear the accumulator, count, operand and last registers.
REQ-032 During reset: in_ready=0, add_load=0, add_ack=0, out_valid=0; add_num1, add_num2, out_data and out_count are all 0.
REQ-033 Reset mid-WAIT SHALL abandon the transaction without add_ack; the adder shares the reset.
REQ-034 in_ready SHALL rise in the first cycle after reset deasserts.

Verification
REQ-035 Single term 0x3F800000 with last -> out_data=0x3F800000, out_count=1, add_load never asserted.
REQ-036 Terms 0x3F800000, 0x40000000, 0x3F000000 (last), with adder model -> exactly 2 add_load pulses, out_data=0x40600000, out_count=3.
REQ-037 Terms 0x00000000, 0x40000000 (last) -> out_data=0x40000000, out_count=2, no add_load; same result for 0x80000000 as the first term.
REQ-038 add_ready delayed 10 cycles -> one add_load pulse, add_num stable throughout, one add_ack pulse coincident with add_ready.
REQ-039 out_ready held low 5 cycles in DONE -> out_valid, out_data and out_count stable, in_ready=0; release -> IDLE next cycle.
REQ-040 reset pulsed low during WAIT -> all outputs 0 while low, no add_ack, in_ready=1 the first cycle after release.

Source files
------------

// File: rtl/fp_accum_seq.sv
// fp_accum_seq: sequences a stream of IEEE-754 single-precision terms through
// an external floating-point adder and presents one sum per group.
//
// Ports
//   clk                     single clock, rising edge
//   reset                   asynchronous, active-low
//   in_valid/in_data/in_last/in_ready
//                           term input handshake; in_last marks the group end
//   add_load                one-cycle strobe starting an adder transaction
//   add_num1/add_num2       adder operands (accumulator, term)
//   add_result/add_ready    adder sum and its valid flag
//   add_ack                 sum consumed; releases the adder
//   out_valid/out_data/out_count/out_ready
//                           group sum output handshake with the term count
//
// Terms that cannot change the sum without arithmetic (the first term of a
// group, a +/-0 term, or a +/-0 accumulator) are handled in place without
// occupying the adder.
module fp_accum_seq #(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [31:0]        in_data,
    input  logic               in_last,
    output logic               in_ready,
    output logic               add_load,
    output logic [31:0]        add_num1,
    output logic [31:0]        add_num2,
    input  logic [31:0]        add_result,
    input  logic               add_ready,
    output logic               add_ack,
    output logic               out_valid,
    output logic [31:0]        out_data,
    output logic [COUNT_W-1:0] out_count,
    input  logic               out_ready
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t               r_state;
    logic [31:0]          r_acc;
    logic [31:0]          r_operand;
    logic                 r_last;
    logic [COUNT_W-1:0]   r_count;

    state_t               w_state_nxt;
    logic [31:0]          w_acc_nxt;
    logic [31:0]          w_operand_nxt;
    logic                 w_last_nxt;
    logic [COUNT_W-1:0]   w_count_nxt;
    logic                 w_accept;
    logic [COUNT_W-1:0]   w_count_inc;

    // While reset is held the FSM already sits in IDLE, so in_ready is
    // additionally gated by reset to keep the input closed until release.
    assign in_ready  = reset && (r_state == IDLE);
    assign w_accept  = in_valid && in_ready;

    assign add_load  = (r_state == ISSUE);
    assign add_ack   = (r_state == WAIT) && add_ready;
    // Accumulator and operand do not change between ISSUE and add_ack, so the
    // operands are stable for the whole transaction without extra registers.
    assign add_num1  = r_acc;
    assign add_num2  = r_operand;

    assign out_valid = (r_state == DONE);
    assign out_data  = out_valid ? r_acc   : '0;
    assign out_count = out_valid ? r_count : '0;

    // Term counter saturates at all-ones.
    assign w_count_inc = (r_count == '1) ? r_count : r_count + COUNT_W'(1);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; a missing default here would infer a latch.
        w_state_nxt   = r_state;
        w_acc_nxt     = r_acc;
        w_operand_nxt = r_operand;
        w_last_nxt    = r_last;
        w_count_nxt   = r_count;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_operand_nxt = in_data;
                    w_last_nxt    = in_last;
                    w_count_nxt   = w_count_inc;
                    if (r_count == '0) begin
                        // First term of the group seeds the accumulator.
                        w_acc_nxt   = in_data;
                        w_state_nxt = in_last ? DONE : IDLE;
                    end else if (in_data[30:0] == 31'd0) begin
                        // +/-0 term leaves the sum unchanged.
                        w_state_nxt = in_last ? DONE : IDLE;
                    end else if (r_acc[30:0] == 31'd0) begin
                        // +/-0 accumulator: the sum is simply the term.
                        w_acc_nxt   = in_data;
                        w_state_nxt = in_last ? DONE : IDLE;
                    end else begin
                        w_state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (add_ready) begin
                    w_acc_nxt   = add_result;
                    w_state_nxt = r_last ? DONE : IDLE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_acc_nxt   = '0;
                    w_count_nxt = '0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_operand <= '0;
            r_last    <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_acc     <= w_acc_nxt;
            r_operand <= w_operand_nxt;
            r_last    <= w_last_nxt;
            r_count   <= w_count_nxt;
        end
    end

endmodule

// File: tb/tb_fp_accum_seq.sv
// Testbench for fp_accum_seq. Expected group sums are pushed into a scoreboard
// queue when a group is issued; a monitor pops and compares on every output
// transfer. An adder model answers add_load with hand-computed sums.
module tb_fp_accum_seq;

    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [31:0]   in_data;
    logic          in_last;
    logic          in_ready;
    logic          add_load;
    logic [31:0]   add_num1;
    logic [31:0]   add_num2;
    logic [31:0]   add_result = '0;
    logic          add_ready;
    logic          add_ready_m = 1'b0;
    logic          stray_ready = 1'b0;
    logic          add_ack;
    logic          out_valid;
    logic [31:0]   out_data;
    logic [CW-1:0] out_count;
    logic          out_ready;

    assign add_ready = add_ready_m | stray_ready;

    always #5 clk = ~clk;

    fp_accum_seq #(.COUNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .add_load   (add_load),
        .add_num1   (add_num1),
        .add_num2   (add_num2),
        .add_result (add_result),
        .add_ready  (add_ready),
        .add_ack    (add_ack),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_count  (out_count),
        .out_ready  (out_ready)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0]   data;
        logic [CW-1:0] cnt;
    } res_t;

    typedef struct {
        logic [31:0] n1;
        logic [31:0] n2;
        logic [31:0] sum;
    } add_t;

    res_t sb_q[$];
    add_t add_q[$];
    int   adder_delay = 2;
    int   n_load = 0;
    int   n_ack  = 0;

    // Event counter and protocol checks on the adder handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (add_load) n_load++;
            if (add_ack)  n_ack++;
            if (add_load || add_ack)
                check("load_ack_exclusive", 32'(add_load && add_ack), 32'd0);
            if (add_ack)
                check("ack_needs_ready", 32'(add_ready), 32'd1);
        end
    end

    // Scoreboard monitor: compare every output transfer against the queue.
    initial begin
        res_t r;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_empty_on_output", 32'(sb_q.size()), 32'd1);
                end else begin
                    r = sb_q.pop_front();
                    check("out_data", out_data, r.data);
                    check("out_count", 32'(out_count), 32'(r.cnt));
                end
            end
        end
    end

    // Adder model: checks operands on add_load, waits adder_delay cycles while
    // checking operand stability, then presents the sum for one cycle.
    initial begin
        add_t        t;
        logic [31:0] h1, h2;
        bit          aborted;
        forever begin
            @(negedge clk);
            if (add_load) begin
                if (add_q.size() == 0) begin
                    check("add_q_empty_on_load", 32'(add_q.size()), 32'd1);
                end else begin
                    t = add_q.pop_front();
                    check("add_num1", add_num1, t.n1);
                    check("add_num2", add_num2, t.n2);
                    h1 = add_num1;
                    h2 = add_num2;
                    aborted = 1'b0;
                    for (int i = 0; i < adder_delay; i++) begin
                        @(negedge clk);
                        if (!reset) begin
                            aborted = 1'b1;
                            break;
                        end
                        check("num1_stable", add_num1, h1);
                        check("num2_stable", add_num2, h2);
                        check("no_early_ack", 32'(add_ack), 32'd0);
                    end
                    if (!aborted) begin
                        @(posedge clk);
                        #1;
                        add_result  = t.sum;
                        add_ready_m = 1'b1;
                        @(negedge clk);
                        check("ack_with_ready", 32'(add_ack), 32'd1);
                        check("num1_at_ack", add_num1, h1);
                        check("num2_at_ack", add_num2, h2);
                        @(posedge clk);
                        #1;
                        add_ready_m = 1'b0;
                    end
                end
            end
        end
    end

    task automatic send_term(input logic [31:0] d, input logic l);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                @(posedge clk);
                break;
            end
        end
        #1;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        check("term_accepted", 32'(ok), 32'd1);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("group_done", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),  32'd0);
        check({tag, "_add_load"},  32'(add_load),  32'd0);
        check({tag, "_add_ack"},   32'(add_ack),   32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_add_num1"},  add_num1,       32'd0);
        check({tag, "_add_num2"},  add_num2,       32'd0);
        check({tag, "_out_data"},  out_data,       32'd0);
        check({tag, "_out_count"}, 32'(out_count), 32'd0);
    endtask

    initial begin
        int l0, a0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Single term: direct write, out_valid the cycle after acceptance.
        sb_q.push_back('{32'h3F800000, 2'd1});
        l0 = n_load;
        send_term(32'h3F800000, 1'b1);
        @(negedge clk);
        check("single_latency", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        check("single_no_load", 32'(n_load - l0), 32'd0);

        // 1.0 + 2.0 + 0.5 = 3.5 through two adder transactions.
        adder_delay = 2;
        add_q.push_back('{32'h3F800000, 32'h40000000, 32'h40400000});
        add_q.push_back('{32'h40400000, 32'h3F000000, 32'h40600000});
        sb_q.push_back('{32'h40600000, 2'd3});
        l0 = n_load;
        a0 = n_ack;
        send_term(32'h3F800000, 1'b0);
        send_term(32'h40000000, 1'b0);
        send_term(32'h3F000000, 1'b1);
        wait_done();
        check("three_loads", 32'(n_load - l0), 32'd2);
        check("three_acks", 32'(n_ack - a0), 32'd2);

        // Zero bypass with +0 and -0 as the first term.
        sb_q.push_back('{32'h40000000, 2'd2});
        l0 = n_load;
        send_term(32'h00000000, 1'b0);
        send_term(32'h40000000, 1'b1);
        wait_done();
        check("pos_zero_no_load", 32'(n_load - l0), 32'd0);

        sb_q.push_back('{32'h40000000, 2'd2});
        l0 = n_load;
        send_term(32'h80000000, 1'b0);
        send_term(32'h40000000, 1'b1);
        wait_done();
        check("neg_zero_no_load", 32'(n_load - l0), 32'd0);

        // Slow adder: 2.0 + 3.0 = 5.0 with add_ready 10 cycles late.
        adder_delay = 10;
        add_q.push_back('{32'h40000000, 32'h40400000, 32'h40A00000});
        sb_q.push_back('{32'h40A00000, 2'd2});
        l0 = n_load;
        a0 = n_ack;
        send_term(32'h40000000, 1'b0);
        send_term(32'h40400000, 1'b1);
        wait_done();
        check("slow_one_load", 32'(n_load - l0), 32'd1);
        check("slow_one_ack", 32'(n_ack - a0), 32'd1);
        adder_delay = 2;

        // Output back-pressure: DONE holds for 5 cycles, then releases.
        out_ready = 1'b0;
        sb_q.push_back('{32'h40400000, 2'd1});
        send_term(32'h40400000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_out_data", out_data, 32'h40400000);
            check("hold_out_count", 32'(out_count), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("release_in_ready", 32'(in_ready), 32'd1);
        check("release_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // add_ready outside WAIT is ignored.
        stray_ready = 1'b1;
        @(negedge clk);
        check("stray_no_ack", 32'(add_ack), 32'd0);
        @(posedge clk);
        #1 stray_ready = 1'b0;
        @(negedge clk);
        check("stray_still_idle", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Counter saturation: five zero terms on a 2-bit counter.
        sb_q.push_back('{32'h00000000, 2'd3});
        l0 = n_load;
        for (int i = 0; i < 4; i++) send_term(32'h00000000, 1'b0);
        send_term(32'h00000000, 1'b1);
        wait_done();
        check("sat_no_load", 32'(n_load - l0), 32'd0);

        // Reset while waiting on the adder.
        adder_delay = 30;
        add_q.push_back('{32'h3F800000, 32'h40000000, 32'h40400000});
        a0 = n_ack;
        send_term(32'h3F800000, 1'b0);
        send_term(32'h40000000, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("in_wait_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset_outputs("midwait");
        end
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("midwait_in_ready_release", 32'(in_ready), 32'd1);
        check("midwait_no_ack", 32'(n_ack - a0), 32'd0);
        @(posedge clk);
        #1;
        adder_delay = 2;

        // Accumulator and count start clean after the abandoned group.
        sb_q.push_back('{32'h3F000000, 2'd1});
        send_term(32'h3F000000, 1'b1);
        wait_done();

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        check("add_q_drained", 32'(add_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
